// File: rtl/prio_enc_arb_if.sv
// prio_enc_arb_if: request/grant handshake bundle between request sources and the arbiter
interface prio_enc_arb_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);
  logic         en;
  logic [N-1:0] din;
  logic         ready;
  logic [W-1:0] y;
  logic [N-1:0] grant;
  logic         valid;
  modport master (output en, din, ready, input y, grant, valid);
  modport slave  (input en, din, ready, output y, grant, valid);
endinterface

// File: rtl/prio_enc_arb.sv
// prio_enc_arb: registered N-input priority encoder/arbiter, fixed or round-robin, valid/ready output
module prio_enc_arb #(
  parameter int N  = 8,
  parameter bit RR = 1'b0
) (
  input logic          clk,
  input logic          rst,
  prio_enc_arb_if.slave bus
);
  localparam int W = $clog2(N);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
  logic [0:0]   state;
  logic [W-1:0] ptr;
  logic [W-1:0] win;
  logic         hit;
  logic         take;
  logic         load;
  int           c;
  // search downward from ptr, wrapping modulo N; first set request wins
  always_comb begin
    win = '0;
    hit = 1'b0;
    c   = 0;
    for (int j = 0; j < N; j++) begin
      c = (int'(ptr) + N - j) % N;
      if (!hit && bus.din[c]) begin
        hit = 1'b1;
        win = W'(c);
      end
    end
  end
  assign take      = (state == IDLE) || bus.ready;
  assign load      = take && bus.en && hit;
  assign bus.valid = (state == HOLD);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bus.y     <= '0;
      bus.grant <= '0;
      ptr       <= W'(N - 1);
    end else if (take) begin
      state     <= load ? HOLD : IDLE;
      bus.y     <= load ? win : bus.y;
      bus.grant <= load ? (N'(1) << win) : '0;
      ptr       <= (load && RR) ? ((win == '0) ? W'(N - 1) : win - W'(1)) : (RR ? ptr : W'(N - 1));
    end
  end
endmodule

// File: tb/tb_prio_enc_arb.sv
// tb_prio_enc_arb: directed and random checks of fixed (N=8) and round-robin (N=8, N=5) arbiters against a search-order model
module tb_prio_enc_arb;
  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] din;
  logic       ready;
  int checks   = 0;
  int failures = 0;
  prio_enc_arb_if #(.N(8)) i0 ();
  prio_enc_arb_if #(.N(8)) i1 ();
  prio_enc_arb_if #(.N(5)) i2 ();
  assign i0.en = en;  assign i0.din = din;      assign i0.ready = ready;
  assign i1.en = en;  assign i1.din = din;      assign i1.ready = ready;
  assign i2.en = en;  assign i2.din = din[4:0]; assign i2.ready = ready;
  prio_enc_arb #(.N(8), .RR(1'b0)) u0 (.clk(clk), .rst(rst), .bus(i0));
  prio_enc_arb #(.N(8), .RR(1'b1)) u1 (.clk(clk), .rst(rst), .bus(i1));
  prio_enc_arb #(.N(5), .RR(1'b1)) u2 (.clk(clk), .rst(rst), .bus(i2));
  always #5 clk = ~clk;
  int mn[3]  = '{8, 8, 5};
  bit mrr[3] = '{1'b0, 1'b1, 1'b1};
  int mp[3];
  int my[3];
  bit mv[3];
  function automatic int pick(logic [7:0] d, int p, int n);
    for (int j = 0; j < n; j++)
      if (d[(p - j + n) % n]) return (p - j + n) % n;
    return -1;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mp[i] = mn[i] - 1;
      my[i] = 0;
      mv[i] = 1'b0;
    end
  endtask
  task automatic model_step();
    logic [7:0] d;
    int k;
    for (int i = 0; i < 3; i++) begin
      if (!mv[i] || ready) begin
        d = din & (8'hFF >> (8 - mn[i]));
        k = pick(d, mp[i], mn[i]);
        if (en && k >= 0) begin
          my[i] = k;
          mv[i] = 1'b1;
          if (mrr[i]) mp[i] = (k + mn[i] - 1) % mn[i];
        end else mv[i] = 1'b0;
      end
    end
  endtask
  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    int oy[3];
    int ov[3];
    int og[3];
    oy[0] = int'(i0.y);     oy[1] = int'(i1.y);     oy[2] = int'(i2.y);
    ov[0] = int'(i0.valid); ov[1] = int'(i1.valid); ov[2] = int'(i2.valid);
    og[0] = int'(i0.grant); og[1] = int'(i1.grant); og[2] = int'(i2.grant);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("valid%0d", i), ov[i], int'(mv[i]));
      chk($sformatf("y%0d", i), oy[i], my[i]);
      chk($sformatf("grant%0d", i), og[i], mv[i] ? (1 << my[i]) : 0);
    end
  endtask
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask
  task automatic pulse_rst();
    rst = 1'b1;
    model_reset();
    #2;
    rst = 1'b0;
  endtask
  int s1[6] = '{7, 4, 0, 7, 4, 0};
  int s2[5] = '{4, 2, 1, 4, 2};
  initial begin
    clk = 1'b0; rst = 1'b1; en = 1'b0; din = '0; ready = 1'b0;
    model_reset();
    #12;
    check_all();
    rst = 1'b0;
    en = 1'b1; din = 8'h80; ready = 1'b0;
    tick();
    chk("hold_y7", int'(i0.y), 7);
    chk("hold_valid", int'(i0.valid), 1);
    #3 rst = 1'b1;
    model_reset();
    #1;
    chk("async_valid", int'(i0.valid), 0);
    chk("async_y", int'(i0.y), 0);
    chk("async_grant", int'(i0.grant), 0);
    check_all();
    #1 rst = 1'b0;
    din = 8'h01; ready = 1'b1;
    tick();
    chk("post_rst_y", int'(i0.y), 0);
    for (int i = 0; i < 8; i++) begin
      din = 8'(1 << i);
      tick();
      chk("walk_y", int'(i0.y), i);
      chk("walk_valid", int'(i0.valid), 1);
      chk("walk_grant", int'(i0.grant), 1 << i);
    end
    din = 8'h00;
    tick();
    chk("walk_end_valid", int'(i0.valid), 0);
    din = 8'h96;
    tick();
    chk("bp_y", int'(i0.y), 7);
    chk("bp_grant", int'(i0.grant), 8'h80);
    ready = 1'b0; en = 1'b0; din = 8'h01;
    repeat (3) begin
      tick();
      chk("bp_hold_y", int'(i0.y), 7);
      chk("bp_hold_valid", int'(i0.valid), 1);
    end
    ready = 1'b1; en = 1'b1;
    tick();
    chk("bp_release_y", int'(i0.y), 0);
    pulse_rst();
    din = 8'h91; ready = 1'b1; en = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("rr8_y", int'(i1.y), s1[c]);
    end
    pulse_rst();
    for (int c = 0; c < 12; c++) begin
      ready = (c % 2 == 0);
      tick();
      chk("rr8_stall_y", int'(i1.y), s1[c / 2]);
      chk("rr8_stall_valid", int'(i1.valid), 1);
    end
    pulse_rst();
    din = 8'h16; ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("rr5_y", int'(i2.y), s2[c]);
      chk("rr5_range", int'(i2.y <= 3'd4), 1);
    end
    pulse_rst();
    ready = 1'b0; en = 1'b0; din = 8'hFF;
    tick();
    chk("gate_en0", int'(i0.valid), 0);
    en = 1'b1; din = 8'h00;
    tick();
    chk("gate_din0", int'(i0.valid), 0);
    din = 8'h91;
    tick();
    chk("gate_first_y", int'(i1.y), 7);
    ready = 1'b1; din = 8'h00;
    repeat (4) tick();
    chk("gate_idle_valid", int'(i1.valid), 0);
    din = 8'h91;
    tick();
    chk("gate_ptr_kept", int'(i1.y), 4);
    pulse_rst();
    repeat (400) begin
      en    = ($urandom_range(0, 4) != 0);
      din   = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
      ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/prio_enc_arb.md
# prio_enc_arb

Parametrised, registered N-input priority encoder/arbiter with a valid/ready output handshake and a selectable fixed-priority or round-robin mode. It generalises the combinational 8-to-3 priority encoder: it captures a winner from a request vector, holds it stable until the consumer accepts it, and sustains one grant per cycle under continuous acceptance. It sits between request sources (interrupt lines, channel requests) and a single downstream consumer.

## Interface
- N, 8: number of request inputs; N ≥ 2, need not be a power of 2.
- W, $clog2(N): index width (derived, not overridden).
- RR, 0: 0 = fixed priority (highest index wins); 1 = round-robin.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- EN  in  1  enable; when 0, no new winner is loaded.
- Din  in  N  request vector; bit i = request i.
- ready  in  1  consumer accepts the current result when ready=1 and valid=1.
- Y  out  W  registered index of the winning request.
- grant  out  N  registered one-hot of Y; all zeros when valid=0.
- valid  out  1  Y/grant hold a result not yet accepted.

## Operation
- Two states:
  - IDLE: valid=0.
  - HOLD: valid=1.
- Load condition: EN=1 and Din≠0, evaluated at an edge where the block is in IDLE, or in HOLD with ready=1 (handshake).
- IDLE:
  - Load condition true → load winner, go to HOLD.
  - Otherwise → stay in IDLE; Y keeps its last value, grant=0.
- HOLD with ready=0:
  - Y, grant and valid hold.
  - Din and EN changes are ignored.
  - EN falling does not drop valid.
- HOLD with ready=1 (handshake):
  - Load condition true → load new winner, stay in HOLD (back-to-back, no bubble).
  - Otherwise → go to IDLE, valid=0, grant=0.
- Priority pointer ptr (W bits), reset value N-1.
- Search order: ptr, ptr-1, …, 0, N-1, …, ptr+1, wrapping modulo N. The winner k is the first index in this order with Din[k]=1.
- On every load:
  - RR=1: ptr ← (k-1) mod N, so k becomes lowest priority next time.
  - RR=0: ptr stays N-1, giving pure highest-index-wins.
- Indices ≥ N never appear on Y.
- Single-request Din: the winner is that index in both modes.

## Timing
- Reset values (async, immediate): valid=0, Y=0, grant=0, ptr=N-1, state IDLE.
- Reset asserted mid-HOLD drops valid in the same cycle without waiting for a clock edge.
- The first load after rst deasserts uses ptr=N-1.
- Latency: a request sampled at edge t appears on Y/valid after edge t; outputs are stable for the whole following cycle.
- Throughput: one accepted grant per cycle while ready=1 and requests persist.
- ready is sampled only when valid=1; ready with valid=0 has no effect.
- Din is sampled only at load edges; pulses between load edges are lost (no request latching).
- grant = one-hot(Y) whenever valid=1, and changes on the same edges as Y.
- The pointer update and the load at a handshake edge use the pre-update ptr; the new ptr applies from the next load onward.

## Test plan
- Reset mid-HOLD:
  - Load Din=0x80 (Y=7, valid=1), ready=0, then assert rst between edges.
  - Required: valid=0, Y=0, grant=0 immediately.
  - After release, Din=0x01 → Y=0 next edge.
- Fixed mode, N=8, EN=1, ready=1, Din walking one-hot 0x01→0x80 every cycle:
  - Required: Y=0..7 each one cycle after its Din, valid continuously 1, grant=Din delayed one cycle.
  - Then Din=0x00 → valid=0 after the next edge.
- Fixed mode, hold under backpressure:
  - Din=0x96 → Y=7, grant=0x80.
  - ready=0 for 3 cycles while Din=0x01 and EN=0: Y stays 7, valid stays 1.
  - ready=1 with EN=1 → Y=0 next edge.
- Round-robin, N=8, Din=0x91 held, EN=1, ready=1:
  - Required: Y sequence 7,4,0,7,4,0.
  - With ready toggling 1/0, the same sequence, each value held through the stalls.
- Round-robin, N=5, Din=5'b10110 held, ready=1:
  - Required: Y sequence 4,2,1,4,2.
  - Y never exceeds 4; grant is 5 bits one-hot.
- Gating:
  - EN=0 with Din=0xFF: valid stays 0.
  - EN=1 with Din=0: valid stays 0.
  - ready=1 while valid=0: no state change, and ptr unchanged, as checked by the next winner.
